// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback stage wrapped around an external Alu.
// Latches operands from a small register file, captures Alu results and hands them downstream.
module alu_issue_ctrl #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_sel,
  input  logic [$clog2(NREGS)-1:0] in_rd,
  input  logic [$clog2(NREGS)-1:0] in_rs1,
  input  logic [$clog2(NREGS)-1:0] in_rs2,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_sel,
  input  logic [WIDTH-1:0]         alu_y,
  input  logic [4:0]               alu_flags,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_y,
  output logic [4:0]               out_flags,
  output logic [$clog2(NREGS)-1:0] out_rd,
  output logic [4:0]               sticky_flags,
  input  logic                     clr_sticky,
  output logic [CNT_W-1:0]         ops_done
);

  // state | meaning
  // IDLE  | ready to accept an operation
  // EXEC  | latched operands on the Alu, result captured at end of cycle
  // RESP  | result presented downstream, waiting for out_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int RW = $clog2(NREGS);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       sel_q;
  logic [RW-1:0]    rd_q;

  assign alu_a   = op_a;
  assign alu_b   = op_b;
  assign alu_sel = sel_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Writeback is assigned after the host write so it wins on an index collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      op_a         <= '0;
      op_b         <= '0;
      sel_q        <= '0;
      rd_q         <= '0;
      out_y        <= '0;
      out_flags    <= '0;
      out_rd       <= '0;
      sticky_flags <= '0;
      ops_done     <= '0;
    end else begin
      if (wr_en) rf[wr_addr] <= wr_data;

      if (state == IDLE && in_valid) begin
        op_a  <= rf[in_rs1];
        op_b  <= rf[in_rs2];
        sel_q <= in_sel;
        rd_q  <= in_rd;
      end

      if (state == EXEC) begin
        rf[rd_q]     <= alu_y;
        out_y        <= alu_y;
        out_flags    <= alu_flags;
        out_rd       <= rd_q;
        sticky_flags <= (clr_sticky ? 5'b0 : sticky_flags) | alu_flags;
      end else if (clr_sticky) begin
        sticky_flags <= '0;
      end

      if (out_valid && out_ready) ops_done <= ops_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed plus randomized checks of the issue/writeback stage against
// a transaction-level model; a behavioural Alu stand-in drives alu_y/alu_flags.
module tb_alu_issue_ctrl;
  localparam int WIDTH = 4;
  localparam int NREGS = 4;
  localparam int RW    = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [2:0]       in_sel;
  logic [RW-1:0]    in_rd, in_rs1, in_rs2;
  logic             wr_en;
  logic [RW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic [2:0]       alu_sel;
  logic [4:0]       alu_flags;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] out_y;
  logic [4:0]       out_flags;
  logic [RW-1:0]    out_rd;
  logic [4:0]       sticky_flags;
  logic             clr_sticky;
  logic [CNT_W-1:0] ops_done;

  alu_issue_ctrl #(.WIDTH(WIDTH), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .alu_flags(alu_flags), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_flags(out_flags), .out_rd(out_rd), .sticky_flags(sticky_flags),
    .clr_sticky(clr_sticky), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  // returns {sign, zero, overflow, parity, carry, y}
  function automatic logic [8:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] s);
    logic [4:0] r;
    logic [3:0] y;
    logic c, v;
    r = '0; c = 1'b0; v = 1'b0;
    case (s)
      3'd0: begin r = {1'b0, a} + {1'b0, b}; c = r[4]; end
      3'd1: begin r = {1'b0, a} - {1'b0, b}; c = (a < b); end
      3'd2: r[3:0] = a & b;
      3'd3: r[3:0] = a | b;
      3'd4: r[3:0] = a ^ b;
      3'd5: r[3:0] = ~a;
      3'd6: r[3:0] = {a[2:0], 1'b0};
      default: r[3:0] = {1'b0, a[3:1]};
    endcase
    y = r[3:0];
    if (s == 3'd0) v = (a[3] == b[3]) && (y[3] != a[3]);
    if (s == 3'd1) v = (a[3] != b[3]) && (y[3] != a[3]);
    return {y[3], (y == 4'd0), v, ^y, c, y};
  endfunction

  always_comb {alu_flags, alu_y} = alu_fn(alu_a, alu_b, alu_sel);

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_accept = 0;
  logic [3:0] m_rf [NREGS];
  logic [4:0] m_sticky;
  logic [7:0] m_ops;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_rf[i] = '0;
    m_sticky = '0;
    m_ops = '0;
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [3:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    m_rf[a] = d;
  endtask

  task automatic run_op(input logic [2:0] sel, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input int wait_cycles,
                        input bit exec_wr, input logic [1:0] exec_wa, input logic [3:0] exec_wd,
                        input bit acc_wr, input logic [1:0] acc_wa, input logic [3:0] acc_wd,
                        input bit b2b, input bit chk_gap);
    logic [8:0] r;
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    chk("ready_wait", in_ready, 1);
    in_valid = 1'b1; in_sel = sel; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    if (acc_wr) begin wr_en = 1'b1; wr_addr = acc_wa; wr_data = acc_wd; end
    r = alu_fn(m_rf[rs1], m_rf[rs2], sel);
    tick();
    if (chk_gap) chk("accept_gap", cyc - last_accept, 3);
    last_accept = cyc;
    wr_en = 1'b0;
    if (acc_wr) m_rf[acc_wa] = acc_wd;
    if (!b2b) in_valid = 1'b0;
    chk("exec_in_ready", in_ready, 0);
    chk("exec_out_valid", out_valid, 0);
    if (exec_wr) begin wr_en = 1'b1; wr_addr = exec_wa; wr_data = exec_wd; end
    tick();
    wr_en = 1'b0;
    if (exec_wr) m_rf[exec_wa] = exec_wd;
    m_rf[rd] = r[3:0];
    m_sticky = m_sticky | r[8:4];
    chk("resp_valid", out_valid, 1);
    chk("resp_in_ready", in_ready, 0);
    chk("out_y", out_y, r[3:0]);
    chk("out_flags", out_flags, r[8:4]);
    chk("out_rd", out_rd, rd);
    chk("rf_rd", dut.rf[rd], m_rf[rd]);
    chk("sticky", sticky_flags, m_sticky);
    if (exec_wr && exec_wa != rd) chk("rf_host", dut.rf[exec_wa], m_rf[exec_wa]);
    if (!b2b) out_ready = 1'b0;
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_y", out_y, r[3:0]);
      chk("hold_flags", out_flags, r[8:4]);
      chk("hold_rd", out_rd, rd);
      chk("hold_ops", ops_done, m_ops);
    end
    out_ready = 1'b1;
    tick();
    m_ops = m_ops + 8'd1;
    if (!b2b) out_ready = 1'b0;
    chk("ops_done", ops_done, m_ops);
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    logic [7:0] ops_start;
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0; clr_sticky = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ops", ops_done, 0);
    chk("rst_sticky", sticky_flags, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_alu_a", alu_a, 0);

    // reset asserted for two cycles while an op is in EXEC
    host_wr(2'd1, 4'd3);
    host_wr(2'd2, 4'd4);
    in_valid = 1'b1; in_sel = 3'd0; in_rd = 2'd1; in_rs1 = 2'd1; in_rs2 = 2'd2;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_exec", in_ready, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_ops", ops_done, 0);
    chk("midrst_rf_rd", dut.rf[1], 0);
    tick();
    chk("midrst_no_wb", dut.rf[1], 0);
    chk("midrst_out_y", out_y, 0);

    // ADD 7+9 wraps to 0 with carry and zero
    host_wr(2'd1, 4'd7);
    host_wr(2'd2, 4'd9);
    run_op(3'd0, 2'd3, 2'd1, 2'd2, 0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0, 0, 0);
    chk("add_y", out_y, 4'd0);
    chk("add_flags", out_flags, 5'b01001);
    chk("add_rf3", dut.rf[3], 4'd0);

    // backpressure for 5 cycles
    run_op(3'd4, 2'd0, 2'd1, 2'd2, 5, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0, 0, 0);

    // host write colliding with writeback, then non-colliding
    run_op(3'd0, 2'd2, 2'd1, 2'd1, 0, 1, 2'd2, 4'd5, 0, 2'd0, 4'd0, 0, 0);
    run_op(3'd3, 2'd2, 2'd1, 2'd2, 0, 1, 2'd0, 4'd5, 0, 2'd0, 4'd0, 0, 0);

    // host write on the accept edge is not forwarded; rs1==rs2==rd
    run_op(3'd0, 2'd3, 2'd1, 2'd0, 1, 0, 2'd0, 4'd0, 1, 2'd1, 4'd12, 0, 0);
    run_op(3'd0, 2'd1, 2'd1, 2'd1, 0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0, 0, 0);

    // sticky accumulation and clear in IDLE
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0; m_sticky = '0;
    chk("sticky_clr0", sticky_flags, 0);
    host_wr(2'd0, 4'd8);
    host_wr(2'd1, 4'd3);
    run_op(3'd0, 2'd2, 2'd0, 2'd0, 0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0, 0, 0);
    run_op(3'd1, 2'd3, 2'd1, 2'd1, 0, 0, 2'd0, 4'd0, 0, 2'd0, 4'd0, 0, 0);
    chk("sticky_carry", sticky_flags[0], 1);
    chk("sticky_zero", sticky_flags[3], 1);
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0; m_sticky = '0;
    chk("sticky_clr", sticky_flags, 0);

    // randomized operations
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) host_wr(2'($urandom), 4'($urandom));
      run_op(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 3),
             1'($urandom), 2'($urandom), 4'($urandom),
             1'($urandom), 2'($urandom), 4'($urandom), 0, 0);
    end

    // back-to-back with in_valid and out_ready held high, crossing the counter wrap
    ops_start = m_ops;
    out_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      run_op(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 0,
             0, 2'd0, 4'd0, 0, 2'd0, 4'd0, 1, (k > 0));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    chk("b2b_wrap", ops_done, ops_start);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
